mux8_arbiter: RTL and testbench
===============================

MUX8_ARBITER -- requirements
Module: mux8_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data bit width of each requester channel and of Y.
REQ-002 Parameter MAX_HOLD, default 4: maximum transfers per grant before forced rotation; legal range 1..15.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 ResetN  input  1  reset, asynchronous, active-low.
REQ-005 Req  input  8  per-requester request; bit i belongs to requester i.
REQ-006 X  input  WIDTH x 8 (unpacked array [8])  per-requester data.
REQ-007 Ready  input  1  downstream accepts Y this cycle.
REQ-008 Y  output  WIDTH  selected data, X[S].
REQ-009 Valid  output  1  Y carries a transfer offer.
REQ-010 S  output  3  registered select index of the granted requester.
REQ-011 Gnt  output  8  one-hot registered grant; all-zero when idle.
REQ-012 Ack  output  8  Ack[i] = Gnt[i] & Valid & Ready; transfer completed this cycle.

Function
REQ-013 Two states SHALL exist: IDLE and GRANT.
REQ-014 In IDLE, Gnt=0 and Valid=0; Y SHALL still equal X[S].
REQ-015 In IDLE with Req != 0, the block SHALL select the first set Req bit at or after pointer Ptr, scanning upward with wrap 7->0, load S and Gnt, and enter GRANT on that edge (1-cycle arbitration latency).
REQ-016 In GRANT, Valid SHALL equal Req[S] combinationally; Y SHALL equal X[S] combinationally.
REQ-017 A transfer occurs when Valid & Ready; HoldCnt SHALL increment only on a transfer.
REQ-018 Ready with Valid=0 SHALL have no effect.
REQ-019 Release SHALL occur at the edge where Req[S]=0, or where a transfer occurs with HoldCnt = MAX_HOLD-1.
REQ-020 On release: Ptr <= (S+1) mod 8, HoldCnt <= 0, and a new pick SHALL be made from the current Req using the new Ptr; if one exists, enter GRANT directly (no dead cycle), else enter IDLE.
REQ-021 A requester released by MAX_HOLD and still requesting SHALL be re-granted only when no other requester is pending.
REQ-022 Req dropping while Ready=1 in the same cycle SHALL produce no transfer and no Ack.
REQ-023 Non-granted Req changes SHALL never alter S, Gnt or Valid during GRANT.

Reset
REQ-024 ResetN=0 SHALL asynchronously set state=IDLE, S=0, Gnt=0, Ptr=0, HoldCnt=0; Valid and Ack SHALL read 0 immediately.
REQ-025 Reset asserted mid-grant SHALL abandon the transfer with no Ack; after deassertion arbitration restarts from Ptr=0.

Configuration
REQ-026 Macro MUX8_ARB_HIPRI_EN: when defined, an 8-bit input HiPri SHALL be added; requesters with Req[i]&HiPri[i] SHALL be picked ahead of all others, round-robin among themselves using the same Ptr.
REQ-027 When MUX8_ARB_HIPRI_EN is undefined, the HiPri port SHALL NOT exist and arbitration SHALL be pure round-robin.

Structure
REQ-028 Package mux8_arb_pkg SHALL hold NUM_REQ=8, SEL_W=3, and the state enum (IDLE, GRANT).
REQ-029 Combinational sub-module rr_pick8 (inputs Req, Ptr; outputs Found, Idx) SHALL implement the round-robin scan; the datapath SHALL instantiate the team's 8:1 N-wide mux driven by S.

Verification (WIDTH=8, MAX_HOLD=4, X[i]=8'h10+i)
REQ-030 ResetN=0 with Req=8'hFF -> Gnt=0, Valid=0, S=0, Ack=0.
REQ-031 Req=8'h08, Ready=1 -> edge 1 Gnt=8'h08, S=3, Y=8'h13; 4 Ack[3] pulses, release, re-grant of 3 on next edge with no dead cycle.
REQ-032 Req=8'hFF, Ready=1 -> grant order 0,1,...,7,0, each held exactly 4 transfers.
REQ-033 Serve requester 6 to release (Ptr=7), then Req=8'h81 -> grant 7, then 0.
REQ-034 In GRANT of requester 2, Ready=0 for 5 cycles -> Valid=1, Y=8'h12 stable, HoldCnt unchanged, Ack=0.
REQ-035 ResetN pulsed low mid-grant of requester 5 -> Valid and Gnt drop immediately; after release with Req=8'h24, grant goes to requester 2.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// mux8_arb_pkg: shared constants and types for the 8-requester arbitrated mux.
//   NUM_REQ  - number of requester channels (8)
//   SEL_W    - width of a requester index (3)
//   state_e  - arbiter state (IDLE, GRANT)
//   onehot8  - index -> one-hot grant vector
package mux8_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux8_n.sv
// mux8_n: 8:1 multiplexer of WIDTH-bit channels.
//   sel  in  [2:0]                  channel select
//   din  in  [WIDTH-1:0] x 8        channel data
//   dout out [WIDTH-1:0]            din[sel]
module mux8_n #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] din [8],
  output logic [WIDTH-1:0] dout
);

  assign dout = din[sel];

endmodule

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin scan over 8 request bits.
//   Req   in  [7:0]  candidate request vector
//   Ptr   in  [2:0]  index where the scan starts (scans upward, wraps 7->0)
//   Found out        at least one Req bit is set
//   Idx   out [2:0]  first set bit at or after Ptr (Ptr when nothing found)
module rr_pick8 import mux8_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] Req,
  input  logic [SEL_W-1:0]   Ptr,
  output logic               Found,
  output logic [SEL_W-1:0]   Idx
);

  logic [SEL_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the last hit written is the
  // one closest to Ptr; avoids a break and keeps the loop a plain mux chain.
  always_comb begin
    Found = 1'b0;
    Idx   = Ptr;
    cand  = Ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = Ptr + SEL_W'(i);
      if (Req[cand]) begin
        Found = 1'b1;
        Idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_arbiter.sv
// mux8_arbiter: round-robin arbiter in front of an 8:1 data mux. One requester
// at a time owns the output; it keeps it for up to MAX_HOLD transfers or
// until it drops its request, after which the grant rotates.
//
// Handshake: a transfer happens in a cycle where Valid & Ready are both high.
// Valid is Req[S] while granted (it may drop at any time); Ready without
// Valid has no effect; Ack marks the granted requester's completed transfer.
//
// Optional feature: define MUX8_ARB_HIPRI_EN to add the HiPri input; requests
// with HiPri set win over all others, round-robin among themselves.
//
// Ports:
//   Clk        in   clock, rising edge
//   ResetN     in   asynchronous active-low reset
//   Req        in   [7:0] per-requester request
//   HiPri      in   [7:0] per-requester high priority (MUX8_ARB_HIPRI_EN only)
//   X          in   [WIDTH-1:0] x 8 per-requester data
//   Ready      in   downstream accepts Y
//   Y          out  [WIDTH-1:0] X[S]
//   Valid      out  Y carries a transfer offer
//   S          out  [2:0] registered select of the granted requester
//   Gnt        out  [7:0] one-hot registered grant, zero when idle
//   Ack        out  [7:0] per-requester transfer-completed strobe
//   dbg_state  out  current arbiter state
module mux8_arbiter import mux8_arb_pkg::*; #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic [NUM_REQ-1:0] Req,
`ifdef MUX8_ARB_HIPRI_EN
  input  logic [NUM_REQ-1:0] HiPri,
`endif
  input  logic [WIDTH-1:0]   X [NUM_REQ],
  input  logic               Ready,
  output logic [WIDTH-1:0]   Y,
  output logic               Valid,
  output logic [SEL_W-1:0]   S,
  output logic [NUM_REQ-1:0] Gnt,
  output logic [NUM_REQ-1:0] Ack,
  output state_e             dbg_state
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         hold_q, hold_d;

  logic [NUM_REQ-1:0] pick_req;
  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               xfer;
  logic               rel;

  // Candidate set for the scan: high-priority requests shadow the rest.
  always_comb begin
`ifdef MUX8_ARB_HIPRI_EN
    pick_req = ((Req & HiPri) != '0) ? (Req & HiPri) : Req;
`else
    pick_req = Req;
`endif
  end

  // While granted, the only pick that matters is the one made on release,
  // which must already use the rotated pointer S+1.
  assign pick_ptr = (state_q == GRANT) ? (s_q + SEL_W'(1)) : ptr_q;

  rr_pick8 u_pick (
    .Req   (pick_req),
    .Ptr   (pick_ptr),
    .Found (pick_found),
    .Idx   (pick_idx)
  );

  mux8_n #(.WIDTH(WIDTH)) u_mux (
    .sel  (s_q),
    .din  (X),
    .dout (Y)
  );

  assign Valid     = (state_q == GRANT) && Req[s_q];
  assign xfer      = Valid && Ready;
  assign Ack       = gnt_q & {NUM_REQ{xfer}};
  assign rel       = (state_q == GRANT) &&
                     (!Req[s_q] || (xfer && (hold_q == HOLD_LAST)));
  assign S         = s_q;
  assign Gnt       = gnt_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          s_d     = pick_idx;
          gnt_d   = onehot8(pick_idx);
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d  = pick_ptr;
          hold_d = '0;
          if (pick_found) begin
            // Hand over on the same edge: no idle cycle between owners.
            s_d   = pick_idx;
            gnt_d = onehot8(pick_idx);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (xfer) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      s_q     <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_mux8_arbiter.sv
// tb_mux8_arbiter: directed scenarios for mux8_arbiter (WIDTH=8, MAX_HOLD=4,
// X[i] = 8'h10+i). Expected {Ack, Y} pairs are queued when a scenario starts
// and popped by a monitor on every falling edge that shows an Ack.
module tb_mux8_arbiter;
  import mux8_arb_pkg::*;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             Clk    = 1'b0;
  logic             ResetN = 1'b0;
  logic [7:0]       Req    = 8'hFF;
  logic             Ready  = 1'b1;
  logic [WIDTH-1:0] X [8];
  logic [WIDTH-1:0] Y;
  logic             Valid;
  logic [2:0]       S;
  logic [7:0]       Gnt;
  logic [7:0]       Ack;
  state_e           dbg_state;

  logic [15:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  mux8_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .Req       (Req),
`ifdef MUX8_ARB_HIPRI_EN
    .HiPri     (8'h00),
`endif
    .X         (X),
    .Ready     (Ready),
    .Y         (Y),
    .Valid     (Valid),
    .S         (S),
    .Gnt       (Gnt),
    .Ack       (Ack),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    for (int i = 0; i < 8; i++) X[i] = 8'(16 + i);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every Ack must match the next queued transfer.
  always @(negedge Clk) begin
    if (Ack !== 8'h00) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", {Ack, Y}, 32'h0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("ack_y", {Ack, Y}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    ResetN = 1'b0;
    Req    = 8'h00;
    Ready  = 1'b0;
    repeat (2) @(posedge Clk);
    #1 ResetN = 1'b1;
  endtask

  task automatic push_xfers(input int idx, input int n);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    for (int k = 0; k < n; k++) exp_q.push_back({oh, 8'(16 + idx)});
  endtask

  // Wait until only 'left' expected transfers remain, within 'budget' cycles.
  task automatic wait_left(input string tag, input int left, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > left && n < budget) begin
      @(negedge Clk);
      #1;
      n++;
    end
    check(tag, exp_q.size(), left);
    while (exp_q.size() > left) void'(exp_q.pop_front());
  endtask

  task automatic next_edge();
    @(posedge Clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    // Reset with every requester active.
    next_edge();
    check("rst_gnt", Gnt, 8'h00);
    check("rst_valid", Valid, 1'b0);
    check("rst_s", S, 3'd0);
    check("rst_ack", Ack, 8'h00);
    check("rst_idle_y", Y, 8'h10);

    // Single requester 3: two back-to-back holds, no dead cycle between.
    do_reset();
    Req = 8'h08; Ready = 1'b1;
    push_xfers(3, 8);
    next_edge();
    check("solo_gnt", Gnt, 8'h08);
    check("solo_s", S, 3'd3);
    check("solo_y", Y, 8'h13);
    check("solo_valid", Valid, 1'b1);
    check("solo_state", dbg_state, GRANT);
    wait_left("solo_drain", 0, 8);
    next_edge();
    check("solo_regrant", Gnt, 8'h08);
    Req = 8'h00;
    #1 check("solo_drop_valid", Valid, 1'b0);
    next_edge();
    check("solo_idle_state", dbg_state, IDLE);
    check("solo_idle_gnt", Gnt, 8'h00);
    check("solo_idle_y", Y, 8'h13);

    // All requesting: 0..7 then 0 again, four transfers each.
    do_reset();
    Req = 8'hFF; Ready = 1'b1;
    for (int r = 0; r < 8; r++) push_xfers(r, 4);
    push_xfers(0, 4);
    wait_left("all_drain", 0, 37);
    next_edge();
    check("all_next_gnt", Gnt, 8'h02);
    Req = 8'h00;
    next_edge();

    // Serve 6 to release (pointer moves to 7), then 7 and 0 follow.
    do_reset();
    Req = 8'h40; Ready = 1'b1;
    push_xfers(6, 4);
    push_xfers(7, 4);
    push_xfers(0, 4);
    next_edge();
    check("wrap_gnt6", Gnt, 8'h40);
    Req = 8'hC1;
    #1;
    check("wrap_hold_gnt", Gnt, 8'h40);
    check("wrap_hold_s", S, 3'd6);
    check("wrap_hold_valid", Valid, 1'b1);
    wait_left("wrap_six", 8, 4);
    next_edge();
    check("wrap_gnt7", Gnt, 8'h80);
    Req = 8'h81;
    wait_left("wrap_rest", 0, 8);
    next_edge();
    Req = 8'h00;
    next_edge();

    // Stall requester 2 with Ready low, then it still gets a full hold.
    do_reset();
    Req = 8'h0C; Ready = 1'b0;
    next_edge();
    check("stall_gnt", Gnt, 8'h04);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      check("stall_valid", Valid, 1'b1);
      check("stall_y", Y, 8'h12);
      check("stall_ack", Ack, 8'h00);
    end
    next_edge();
    Ready = 1'b1;
    push_xfers(2, 4);
    wait_left("stall_drain", 0, 4);
    next_edge();
    check("stall_next_gnt", Gnt, 8'h08);
    Req = 8'h00;
    next_edge();

    // Reset in the middle of requester 5's grant.
    do_reset();
    Req = 8'h20; Ready = 1'b1;
    push_xfers(5, 2);
    next_edge();
    check("midrst_gnt5", Gnt, 8'h20);
    wait_left("midrst_pre", 0, 2);
    ResetN = 1'b0;
    #1;
    check("midrst_valid", Valid, 1'b0);
    check("midrst_gnt", Gnt, 8'h00);
    check("midrst_ack", Ack, 8'h00);
    check("midrst_s", S, 3'd0);
    Req = 8'h24;
    next_edge();
    ResetN = 1'b1;
    next_edge();
    check("midrst_regnt", Gnt, 8'h04);
    check("midrst_s2", S, 3'd2);
    check("midrst_y", Y, 8'h12);
    Req = 8'h00;
    #1;
    check("drop_ack", Ack, 8'h00);
    check("drop_valid", Valid, 1'b0);
    next_edge();
    next_edge();

    check("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
